// File: rtl/reg_pipe_if.sv
// reg_pipe_if: upstream/downstream handshake and flush bundle for reg_pipe.
// The slave modport is the pipeline side; the master modport is the producer/consumer side.
interface reg_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             flush;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        output flush,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        input  flush,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/reg_pipe.sv
// reg_pipe: DEPTH-stage valid/ready register pipeline with bubble collapse and synchronous flush.
// Define REG_PIPE_CNT_EN to add the count output (number of valid stages).
module reg_pipe #(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic      clk,
    input  logic      rst,
    reg_pipe_if.slave bus
`ifdef REG_PIPE_CNT_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] count
`endif
);
    // Handshake: a word crosses a boundary at a rising edge where the sender's valid and
    // the receiver's ready are both high; ready is never a function of valid.

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] adv;

    // A stage advances when the downstream takes the head word or any stage at or ahead of it is empty.
    always_comb begin : advance_chain
        logic tail_full;
        tail_full = 1'b1;
        adv       = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            tail_full = tail_full & v[i];
            adv[i]    = bus.out_ready | ~tail_full;
        end
    end

    assign bus.in_ready  = rst & adv[0];
    assign bus.out_valid = v[DEPTH-1];
    assign bus.out_data  = d[DEPTH-1];

    always_ff @(posedge clk) begin
        if (!rst || bus.flush) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d[i] <= RST_VAL;
            end
        end else begin
            if (adv[0]) begin
                v[0] <= bus.in_valid;
                d[0] <= bus.in_data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (adv[i]) begin
                    v[i] <= v[i-1];
                    d[i] <= d[i-1];
                end
            end
        end
    end

`ifdef REG_PIPE_CNT_EN
    localparam int CW = $clog2(DEPTH + 1);

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = bus.in_valid & bus.in_ready;
    assign out_xfer = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (!rst || bus.flush) begin
            count <= '0;
        end else if (in_xfer && !out_xfer) begin
            count <= count + CW'(1);
        end else if (out_xfer && !in_xfer) begin
            count <= count - CW'(1);
        end
    end
`endif

`ifndef SYNTHESIS
    // A stalled head word must not change or vanish.
    hold_on_stall: assert property (@(posedge clk)
        (rst && !bus.flush && bus.out_valid && !bus.out_ready)
        |=> (bus.out_valid && $stable(bus.out_data)));

    no_ready_in_reset: assert property (@(posedge clk) !rst |-> !bus.in_ready);
`endif
endmodule

// File: tb/tb_reg_pipe.sv
// tb_reg_pipe: randomized and directed checks of reg_pipe against a word/position queue model.
// Count checks are compiled in when REG_PIPE_CNT_EN is defined.
module tb_reg_pipe;
    localparam int         WIDTH   = 8;
    localparam int         DEPTH   = 4;
    localparam logic [7:0] RST_VAL = 8'h5A;

    logic clk = 1'b0;
    logic rst;

    reg_pipe_if #(.WIDTH(WIDTH)) bus ();

`ifdef REG_PIPE_CNT_EN
    logic [$clog2(DEPTH+1)-1:0] count;
`endif

    reg_pipe #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .RST_VAL (RST_VAL)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus)
`ifdef REG_PIPE_CNT_EN
        ,
        .count (count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: words in arrival order with the stage each one occupies.
    logic [7:0] exp_q[$];
    int         pos_q[$];
    logic [7:0] out_log[$];
    logic       last_clear = 1'b0;

    function automatic logic exp_in_ready();
        return rst && (bus.out_ready || exp_q.size() < DEPTH);
    endfunction

    function automatic logic exp_out_valid();
        return exp_q.size() > 0 && pos_q[0] == DEPTH - 1;
    endfunction

    function automatic logic [7:0] exp_out_data();
        return (exp_q.size() > 0) ? exp_q[0] : 8'h00;
    endfunction

    task automatic drive(input logic iv, input logic [7:0] id, input logic ordy,
                         input logic fl, input logic rn);
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.out_ready = ordy;
        bus.flush     = fl;
        rst           = rn;
        @(negedge clk);
        if (rst && !bus.flush && bus.out_valid === 1'b1 && bus.out_ready)
            out_log.push_back(bus.out_data);
    endtask

    task automatic tick();
        int   ceil_pos;
        logic acc;
        @(posedge clk);
        last_clear = !rst || bus.flush;
        if (last_clear) begin
            exp_q.delete();
            pos_q.delete();
        end else begin
            acc = bus.in_valid && (bus.out_ready || exp_q.size() < DEPTH);
            if (exp_q.size() > 0 && pos_q[0] == DEPTH - 1 && bus.out_ready) begin
                void'(exp_q.pop_front());
                void'(pos_q.pop_front());
            end
            // Each word steps forward one stage but cannot pass the word ahead of it.
            ceil_pos = DEPTH - 1;
            foreach (pos_q[k]) begin
                pos_q[k] = (pos_q[k] + 1 > ceil_pos) ? ceil_pos : pos_q[k] + 1;
                ceil_pos = pos_q[k] - 1;
            end
            if (acc) begin
                exp_q.push_back(bus.in_data);
                pos_q.push_back(0);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
            checks++;
            if (bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
            end
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        checks++;
        if (bus.out_data !== RST_VAL) begin
            errors++;
            $display("FAIL reset_out_data: got %h want %h", bus.out_data, RST_VAL);
        end
`ifdef REG_PIPE_CNT_EN
        checks++;
        if (count !== '0) begin
            errors++;
            $display("FAIL reset_count: got %0d want 0", count);
        end
`endif
        tick();
    endtask

    task automatic test_latency();
        logic [7:0] pat [3];
        pat = '{8'h11, 8'h22, 8'h33};
        for (int c = 0; c < 9; c++) begin
            drive(c < 3, pat[c % 3], 1'b1, 1'b0, 1'b1);
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL lat_in_ready cyc %0d: got %b want 1", c, bus.in_ready);
            end
            checks++;
            if (bus.out_valid !== (c >= 4 && c <= 6)) begin
                errors++;
                $display("FAIL lat_out_valid cyc %0d: got %b want %b", c, bus.out_valid,
                         (c >= 4 && c <= 6));
            end
            if (c >= 4 && c <= 6) begin
                checks++;
                if (bus.out_data !== pat[c-4]) begin
                    errors++;
                    $display("FAIL lat_out_data cyc %0d: got %h want %h", c, bus.out_data, pat[c-4]);
                end
            end
            tick();
        end
    endtask

    task automatic test_stall();
        logic [7:0] dv;
        out_log.delete();
        for (int c = 0; c < 6; c++) begin
            dv = (c < 4) ? 8'(8'hA0 + c) : 8'hA4;
            drive(1'b1, dv, 1'b0, 1'b0, 1'b1);
            checks++;
            if (bus.in_ready !== (c < 4)) begin
                errors++;
                $display("FAIL stall_in_ready cyc %0d: got %b want %b", c, bus.in_ready, (c < 4));
            end
            checks++;
            if (bus.out_valid !== exp_out_valid()) begin
                errors++;
                $display("FAIL stall_out_valid cyc %0d: got %b want %b", c, bus.out_valid, exp_out_valid());
            end
`ifdef REG_PIPE_CNT_EN
            if (c == 5) begin
                checks++;
                if (count !== 3'd4) begin
                    errors++;
                    $display("FAIL stall_count: got %0d want 4", count);
                end
            end
`endif
            tick();
        end
        drive(1'b1, 8'hA4, 1'b1, 1'b0, 1'b1);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_in_ready: got %b want 1", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA0) begin
            errors++;
            $display("FAIL stall_release_head: got %b/%h want 1/a0", bus.out_valid, bus.out_data);
        end
        tick();
        for (int c = 0; c < 7; c++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
            checks++;
            if (bus.out_valid !== exp_out_valid()) begin
                errors++;
                $display("FAIL stall_drain_valid cyc %0d: got %b want %b", c, bus.out_valid, exp_out_valid());
            end
            tick();
        end
        checks++;
        if (out_log.size() != 5) begin
            errors++;
            $display("FAIL stall_out_words: got %0d want 5", out_log.size());
        end
        foreach (out_log[k]) begin
            checks++;
            if (out_log[k] !== 8'(8'hA0 + k)) begin
                errors++;
                $display("FAIL stall_order idx %0d: got %h want %h", k, out_log[k], 8'(8'hA0 + k));
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b1);
            tick();
        end
        for (int c = 0; c < 20; c++) begin
            drive(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b1);
            checks++;
            if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL b2b_flow cyc %0d: got rdy %b vld %b want 1 1", c, bus.in_ready, bus.out_valid);
            end
            checks++;
            if (bus.out_data !== exp_out_data()) begin
                errors++;
                $display("FAIL b2b_data cyc %0d: got %h want %h", c, bus.out_data, exp_out_data());
            end
            tick();
        end
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
            checks++;
            if (bus.out_valid !== exp_out_valid()) begin
                errors++;
                $display("FAIL b2b_drain cyc %0d: got %b want %b", c, bus.out_valid, exp_out_valid());
            end
            tick();
        end
    endtask

    task automatic test_bubble();
        logic [7:0] w1;
        logic [7:0] w2;
        w1 = 8'($urandom_range(0, 255));
        w2 = 8'($urandom_range(0, 255));
        for (int c = 0; c < 8; c++) begin
            drive(c == 0 || c == 3, (c == 0) ? w1 : w2, 1'b0, 1'b0, 1'b1);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== w1) begin
            errors++;
            $display("FAIL bubble_head: got %b/%h want 1/%h", bus.out_valid, bus.out_data, w1);
        end
`ifdef REG_PIPE_CNT_EN
        checks++;
        if (count !== 3'd2) begin
            errors++;
            $display("FAIL bubble_count: got %0d want 2", count);
        end
`endif
        tick();
        // Compacted words leave on consecutive cycles once released.
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== w2) begin
            errors++;
            $display("FAIL bubble_second: got %b/%h want 1/%h", bus.out_valid, bus.out_data, w2);
        end
        tick();
    endtask

    task automatic test_flush();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b1);
            tick();
        end
        drive(1'b1, 8'hEE, 1'b0, 1'b1, 1'b1);
        tick();
        out_log.delete();
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_out_valid cyc %0d: got %b want 0", c, bus.out_valid);
            end
            if (c == 0) begin
                checks++;
                if (bus.out_data !== RST_VAL) begin
                    errors++;
                    $display("FAIL flush_out_data: got %h want %h", bus.out_data, RST_VAL);
                end
`ifdef REG_PIPE_CNT_EN
                checks++;
                if (count !== '0) begin
                    errors++;
                    $display("FAIL flush_count: got %0d want 0", count);
                end
`endif
            end
            tick();
        end
        checks++;
        if (out_log.size() != 0) begin
            errors++;
            $display("FAIL flush_leak: got %0d words want 0", out_log.size());
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] w;
        w = 8'($urandom_range(0, 255));
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b1);
            tick();
        end
        drive(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mrst_in_ready: got %b want 0", bus.in_ready);
        end
        tick();
        for (int c = 4; c < 10; c++) begin
            drive(c == 4, w, 1'b1, 1'b0, 1'b1);
            if (c == 4) begin
                checks++;
                if (bus.out_valid !== 1'b0 || bus.out_data !== RST_VAL) begin
                    errors++;
                    $display("FAIL mrst_outputs: got %b/%h want 0/%h", bus.out_valid, bus.out_data, RST_VAL);
                end
            end
            checks++;
            if (bus.out_valid !== (c == 8)) begin
                errors++;
                $display("FAIL mrst_latency cyc %0d: got %b want %b", c, bus.out_valid, (c == 8));
            end
            if (c == 8) begin
                checks++;
                if (bus.out_data !== w) begin
                    errors++;
                    $display("FAIL mrst_data: got %h want %h", bus.out_data, w);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 40) == 0, $urandom_range(0, 60) != 0);
            checks++;
            if (bus.in_ready !== exp_in_ready()) begin
                errors++;
                $display("FAIL rnd_in_ready cyc %0d: got %b want %b", c, bus.in_ready, exp_in_ready());
            end
            checks++;
            if (bus.out_valid !== exp_out_valid()) begin
                errors++;
                $display("FAIL rnd_out_valid cyc %0d: got %b want %b", c, bus.out_valid, exp_out_valid());
            end
            if (exp_out_valid()) begin
                checks++;
                if (bus.out_data !== exp_out_data()) begin
                    errors++;
                    $display("FAIL rnd_out_data cyc %0d: got %h want %h", c, bus.out_data, exp_out_data());
                end
            end else if (last_clear) begin
                checks++;
                if (bus.out_data !== RST_VAL) begin
                    errors++;
                    $display("FAIL rnd_clear_data cyc %0d: got %h want %h", c, bus.out_data, RST_VAL);
                end
            end
`ifdef REG_PIPE_CNT_EN
            checks++;
            if (count !== 3'(exp_q.size())) begin
                errors++;
                $display("FAIL rnd_count cyc %0d: got %0d want %0d", c, count, exp_q.size());
            end
`endif
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_stall();
        test_back_to_back();
        test_bubble();
        test_flush();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_pipe.md
REG_PIPE -- requirements
Module: reg_pipe

Interface
REQ-001 Parameter WIDTH, default 8: data width in bits, 1..64.
REQ-002 Parameter DEPTH, default 4: number of register stages, 1..16.
REQ-003 Parameter RST_VAL, default 0: value loaded into every stage data register on reset or flush.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-low.
REQ-006 in_valid  input  1  upstream presents in_data.
REQ-007 in_data  input  WIDTH  upstream data.
REQ-008 in_ready  output  1  block accepts in_data this cycle.
REQ-009 out_valid  output  1  stage DEPTH-1 holds a valid word.
REQ-010 out_data  output  WIDTH  data register of stage DEPTH-1.
REQ-011 out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 flush  input  1  synchronous discard of all held words.
REQ-013 count  output  clog2(DEPTH+1)  number of valid stages; present only with REG_PIPE_CNT_EN.

Function
REQ-014 Each stage i SHALL hold one valid bit v[i] and one WIDTH-bit data register d[i].
REQ-015 Transfer in SHALL occur when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-016 Stage DEPTH-1 SHALL advance (empty or refill) when out_ready || !v[DEPTH-1]; stage i<DEPTH-1 SHALL advance when !v[i] || stage i+1 advances.
REQ-017 in_ready SHALL equal advance of stage 0, and it SHALL NOT depend on in_valid.
REQ-018 On advance, stage i SHALL load v[i-1],d[i-1] (stage 0 loads in_valid,in_data); a non-advancing stage SHALL hold.
REQ-019 Bubbles SHALL collapse: a valid word moves forward into any empty stage ahead of it every cycle, even while out_ready=0.
REQ-020 Unstalled latency SHALL be exactly DEPTH cycles from the input transfer edge to out_valid=1.
REQ-021 Full (all v=1) with out_ready=0: in_ready SHALL be 0 and all stages SHALL hold.
REQ-022 Full with out_ready=1: output and input transfers SHALL occur in the same cycle; throughput SHALL be 1 word/cycle.
REQ-023 d[i] SHALL load only when stage i advances; the data of invalid stages is don't-care but SHALL NOT be X after reset.
REQ-024 Word order SHALL be preserved; no word SHALL be duplicated or dropped except by flush or rst.
REQ-025 flush=1 SHALL clear all v[i] and load RST_VAL into all d[i] at the edge; any input transfer in that cycle SHALL be discarded.
REQ-026 With DEPTH=1 the block SHALL behave as a single registered stage with combinational in_ready = out_ready || !v[0].

Reset
REQ-027 rst=0 at a rising edge SHALL clear all v[i], set all d[i]=RST_VAL, and force out_valid=0, out_data=RST_VAL and count=0.
REQ-028 While rst=0, in_ready SHALL be 0; rst SHALL take priority over flush and data transfers.
REQ-029 Asserting rst mid-stream SHALL discard all held words; the first edge with rst=1 SHALL resume normal operation.

Configuration
REQ-030 Macro REG_PIPE_CNT_EN defined: count port present; count SHALL equal popcount(v) after each edge, +1 on input-only transfer, -1 on output-only transfer, unchanged on both or neither, and 0 on flush or rst.
REQ-031 REG_PIPE_CNT_EN undefined: count port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 WIDTH=8, DEPTH=4, out_ready=1: drive 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 on cycles 4,5,6, with out_valid high exactly those three cycles.
REQ-033 out_ready=0: push 0xA0..0xA4 -> 0xA0..0xA3 accepted, in_ready=0 on the 5th push, count=4; then raise out_ready -> 0xA0..0xA3 out in order and 0xA4 accepted on the first cycle out_ready is high.
REQ-034 Full pipe, out_ready=1, in_valid=1 continuous for 20 cycles -> in_ready stays 1 and one word leaves per cycle with no gaps.
REQ-035 Two words separated by a 2-cycle bubble, out_ready=0 -> both words compact into stages 3 and 2 and count=2.
REQ-036 Pipe holding 3 words, flush=1 with in_valid=1 -> the next cycle shows out_valid=0 and count=0, and the in-flight input never appears at the output.
REQ-037 rst=0 for one edge mid-stream with RST_VAL=0x5A -> out_valid=0, out_data=0x5A and in_ready=0 during reset; the stream restarts cleanly with a DEPTH-cycle latency.
